stage3_fence_sequencer: RTL and testbench

Sequences cache and TLB maintenance for FENCE.I and SFENCE.VMA while the fence instruction sits in the stage-3 memory stage. It issues dcache flush first (write back dirty data), then icache flush, then an I/D TLB fence. It stalls the pipeline until every phase has completed and releases the stall exactly once per fence instruction. It sits between the memory stage, the hazard unit and cache_control_if.

---
 rtl/fence_pkg.sv | 16 +
 rtl/fence_phase_timer.sv | 19 +
 rtl/stage3_fence_sequencer.sv | 107 ++++++++++
 tb/tb_stage3_fence_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fence_pkg.sv
// fence_pkg: shared types and helpers for the stage-3 fence sequencer
package fence_pkg;
  typedef enum logic [2:0] {IDLE, DFLUSH, IFLUSH, TLB, COMPLETE, RELEASE} fence_state_t;
  localparam int ASID_MAX_W = 16;
  typedef struct packed {
    logic                  do_i;
    logic                  do_s;
    logic [31:0]           va;
    logic [ASID_MAX_W-1:0] asid;
    logic                  va_valid;
    logic                  asid_valid;
  } fence_op_t;
  function automatic int tmr_w(input int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/fence_phase_timer.sv
// fence_phase_timer: per-phase cycle counter with clear, first-cycle flag and saturating expire
module fence_phase_timer #(
  parameter int LIMIT = 1024,
  parameter int W = $clog2(LIMIT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic first_o,
  output logic expire_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign first_o = cnt_q == '0;
  assign expire_o = cnt_q == W'(LIMIT - 1);
  // count cycles in the current phase, holding at the expiry value
  always_comb cnt_d = clr_i ? '0 : (expire_o ? cnt_q : cnt_q + 1'b1);
  // counter register
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/stage3_fence_sequencer.sv
// stage3_fence_sequencer: orders dcache flush, icache flush and TLB fence for FENCE.I/SFENCE.VMA
module stage3_fence_sequencer #(
  parameter string ADDRESS_TRANSLATION = "enabled",
  parameter int ASID_W = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ifence_req,
  input  logic              sfence_req,
  input  logic              squash,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  input  logic              rs1_zero,
  input  logic              rs2_zero,
  input  logic              iflush_done,
  input  logic              dflush_done,
  input  logic              itlb_fence_done,
  input  logic              dtlb_fence_done,
  output logic              icache_flush,
  output logic              dcache_flush,
  output logic              itlb_fence,
  output logic              dtlb_fence,
  output logic [31:0]       fence_va,
  output logic [ASID_W-1:0] fence_asid,
  output logic              fence_va_valid,
  output logic              fence_asid_valid,
  output logic              fence_stall,
  output logic              fence_done,
  output logic              fence_timeout
);
  import fence_pkg::*;
  localparam bit XLAT = ADDRESS_TRANSLATION == "enabled";
  localparam int TW = tmr_w(TIMEOUT_CYCLES);
  fence_state_t state_q, state_d;
  fence_op_t op_q, op_d;
  logic i_ok_q, i_ok_d, d_ok_q, d_ok_d, tmo_q, tmo;
  logic accept, first, expire, unused_bits;
  fence_phase_timer #(.LIMIT(TIMEOUT_CYCLES), .W(TW)) u_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (state_d != state_q),
    .first_o (first),
    .expire_o(expire)
  );
  assign accept = state_q == IDLE && (ifence_req || sfence_req) && !squash && !RST;
  assign op_d = '{do_i: ifence_req, do_s: sfence_req, va: rs1_data,
                  asid: ASID_MAX_W'(rs2_data[ASID_W-1:0]),
                  va_valid: !rs1_zero, asid_valid: !rs2_zero};
  assign dcache_flush = state_q == DFLUSH && first;
  assign icache_flush = state_q == IFLUSH && first;
  assign itlb_fence = state_q == TLB && first;
  assign dtlb_fence = itlb_fence;
  assign fence_stall = accept || state_q == DFLUSH || state_q == IFLUSH || state_q == TLB;
  assign fence_done = state_q == COMPLETE;
  assign fence_timeout = tmo_q || tmo;
  assign fence_va = op_q.va;
  assign fence_asid = op_q.asid[ASID_W-1:0];
  assign fence_va_valid = op_q.va_valid;
  assign fence_asid_valid = op_q.asid_valid;
  assign unused_bits = ^{rs2_data, op_q.asid, op_q.do_i};
  // phase sequencing; an expired phase advances as if its done pulse had arrived
  always_comb begin
    state_d = state_q;
    tmo = 1'b0;
    i_ok_d = 1'b0;
    d_ok_d = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = ifence_req ? DFLUSH : (XLAT ? TLB : COMPLETE);
      DFLUSH: if (dflush_done || expire) begin
        state_d = IFLUSH;
        tmo = !dflush_done;
      end
      IFLUSH: if (iflush_done || expire) begin
        state_d = (op_q.do_s && XLAT) ? TLB : COMPLETE;
        tmo = !iflush_done;
      end
      TLB: begin
        i_ok_d = i_ok_q || itlb_fence_done;
        d_ok_d = d_ok_q || dtlb_fence_done;
        if ((i_ok_d && d_ok_d) || expire) begin
          state_d = COMPLETE;
          tmo = !(i_ok_d && d_ok_d);
        end
      end
      COMPLETE: state_d = RELEASE;
      RELEASE: if (!ifence_req && !sfence_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, latched operands, TLB completion flags and sticky timeout
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      op_q <= '0;
      i_ok_q <= 1'b0;
      d_ok_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= accept ? op_d : op_q;
      i_ok_q <= i_ok_d;
      d_ok_q <= d_ok_d;
      tmo_q <= tmo_q || tmo;
    end
  end
endmodule

// File: tb/tb_stage3_fence_sequencer.sv
// tb_stage3_fence_sequencer: directed checks of fence sequencing, latching, release, timeout, squash and reset
module tb_stage3_fence_sequencer;
  logic CLK = 1'b0, RST;
  logic ifence_req, sfence_req, squash, rs1_zero, rs2_zero;
  logic [31:0] rs1_data, rs2_data;
  logic iflush_done, dflush_done, itlb_fence_done, dtlb_fence_done;
  logic icache_flush, dcache_flush, itlb_fence, dtlb_fence;
  logic [31:0] fence_va;
  logic [8:0] fence_asid;
  logic fence_va_valid, fence_asid_valid, fence_stall, fence_done, fence_timeout;
  logic d2_icache_flush, d2_dcache_flush, d2_itlb_fence, d2_dtlb_fence;
  logic [31:0] d2_fence_va;
  logic [8:0] d2_fence_asid;
  logic d2_fence_va_valid, d2_fence_asid_valid, d2_fence_stall, d2_fence_done, d2_fence_timeout;
  int checks = 0, errors = 0;

  stage3_fence_sequencer #(.ADDRESS_TRANSLATION("enabled"), .ASID_W(9), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .ifence_req(ifence_req), .sfence_req(sfence_req), .squash(squash),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_zero(rs1_zero), .rs2_zero(rs2_zero),
    .iflush_done(iflush_done), .dflush_done(dflush_done),
    .itlb_fence_done(itlb_fence_done), .dtlb_fence_done(dtlb_fence_done),
    .icache_flush(icache_flush), .dcache_flush(dcache_flush),
    .itlb_fence(itlb_fence), .dtlb_fence(dtlb_fence),
    .fence_va(fence_va), .fence_asid(fence_asid),
    .fence_va_valid(fence_va_valid), .fence_asid_valid(fence_asid_valid),
    .fence_stall(fence_stall), .fence_done(fence_done), .fence_timeout(fence_timeout));

  stage3_fence_sequencer #(.ADDRESS_TRANSLATION("disabled"), .ASID_W(9), .TIMEOUT_CYCLES(16)) dut2 (
    .CLK(CLK), .RST(RST), .ifence_req(ifence_req), .sfence_req(sfence_req), .squash(squash),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_zero(rs1_zero), .rs2_zero(rs2_zero),
    .iflush_done(iflush_done), .dflush_done(dflush_done),
    .itlb_fence_done(itlb_fence_done), .dtlb_fence_done(dtlb_fence_done),
    .icache_flush(d2_icache_flush), .dcache_flush(d2_dcache_flush),
    .itlb_fence(d2_itlb_fence), .dtlb_fence(d2_dtlb_fence),
    .fence_va(d2_fence_va), .fence_asid(d2_fence_asid),
    .fence_va_valid(d2_fence_va_valid), .fence_asid_valid(d2_fence_asid_valid),
    .fence_stall(d2_fence_stall), .fence_done(d2_fence_done), .fence_timeout(d2_fence_timeout));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ifence_req = 0; sfence_req = 0; squash = 0; rs1_data = 0; rs2_data = 0;
    rs1_zero = 1; rs2_zero = 1; iflush_done = 0; dflush_done = 0;
    itlb_fence_done = 0; dtlb_fence_done = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    repeat (3) tick();
    RST = 0;
    #1;
    checks += 3;
    if ({icache_flush, dcache_flush, itlb_fence, dtlb_fence, fence_stall, fence_done, fence_timeout} !== 7'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000000", {icache_flush, dcache_flush, itlb_fence, dtlb_fence, fence_stall, fence_done, fence_timeout});
    end
    if ({fence_va, fence_asid, fence_va_valid, fence_asid_valid} !== 43'd0) begin
      errors++; $display("FAIL reset_latches got va=%h asid=%h v=%b%b exp 0", fence_va, fence_asid, fence_va_valid, fence_asid_valid);
    end
    if ({d2_fence_stall, d2_fence_done, d2_fence_timeout} !== 3'd0) begin
      errors++; $display("FAIL reset_dut2 got %b exp 000", {d2_fence_stall, d2_fence_done, d2_fence_timeout});
    end
    tick();
  endtask

  task automatic test_ifence();
    for (int c = 0; c < 14; c++) begin
      ifence_req = c < 12; dflush_done = c == 6; iflush_done = c == 10;
      #1;
      checks += 5;
      if (dcache_flush !== (c == 1)) begin errors++; $display("FAIL ifence_dcache c=%0d got %b exp %b", c, dcache_flush, c == 1); end
      if (icache_flush !== (c == 7)) begin errors++; $display("FAIL ifence_icache c=%0d got %b exp %b", c, icache_flush, c == 7); end
      if (fence_done !== (c == 11)) begin errors++; $display("FAIL ifence_done c=%0d got %b exp %b", c, fence_done, c == 11); end
      if (fence_stall !== (c <= 10)) begin errors++; $display("FAIL ifence_stall c=%0d got %b exp %b", c, fence_stall, c <= 10); end
      if ({itlb_fence, dtlb_fence} !== 2'b00) begin errors++; $display("FAIL ifence_tlb c=%0d got %b exp 00", c, {itlb_fence, dtlb_fence}); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_sfence();
    for (int c = 0; c < 11; c++) begin
      sfence_req = c < 9;
      rs1_data = c == 0 ? 32'h8000_1000 : 32'hDEAD_BEEF;
      rs2_data = c == 0 ? 32'h0000_0005 : 32'h0000_01FF;
      rs1_zero = c != 0; rs2_zero = c != 0;
      dtlb_fence_done = c == 3; itlb_fence_done = c == 7;
      #1;
      checks += 8;
      if (itlb_fence !== (c == 1)) begin errors++; $display("FAIL sfence_itlb c=%0d got %b exp %b", c, itlb_fence, c == 1); end
      if (dtlb_fence !== (c == 1)) begin errors++; $display("FAIL sfence_dtlb c=%0d got %b exp %b", c, dtlb_fence, c == 1); end
      if (fence_done !== (c == 8)) begin errors++; $display("FAIL sfence_done c=%0d got %b exp %b", c, fence_done, c == 8); end
      if (fence_stall !== (c <= 7)) begin errors++; $display("FAIL sfence_stall c=%0d got %b exp %b", c, fence_stall, c <= 7); end
      if ({dcache_flush, icache_flush} !== 2'b00) begin errors++; $display("FAIL sfence_cache c=%0d got %b exp 00", c, {dcache_flush, icache_flush}); end
      if (d2_fence_done !== (c == 1)) begin errors++; $display("FAIL notrans_done c=%0d got %b exp %b", c, d2_fence_done, c == 1); end
      if ({d2_itlb_fence, d2_dtlb_fence, d2_fence_stall} !== {2'b00, c == 0}) begin
        errors++; $display("FAIL notrans_tlb_stall c=%0d got %b exp %b", c, {d2_itlb_fence, d2_dtlb_fence, d2_fence_stall}, {2'b00, c == 0});
      end
      if (c >= 1 && {fence_va, fence_asid, fence_va_valid, fence_asid_valid} !== {32'h8000_1000, 9'd5, 2'b11}) begin
        errors++; $display("FAIL sfence_latch c=%0d got va=%h asid=%0d v=%b%b exp va=80001000 asid=5 v=11", c, fence_va, fence_asid, fence_va_valid, fence_asid_valid);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_both();
    for (int c = 0; c < 8; c++) begin
      ifence_req = c < 6; sfence_req = c < 6;
      rs1_data = 32'h1234_5000; rs1_zero = 0; rs2_data = 0; rs2_zero = 1;
      dflush_done = c == 1; iflush_done = c == 2;
      itlb_fence_done = c == 1 || c == 4; dtlb_fence_done = c == 1 || c == 4;
      #1;
      checks += 7;
      if (dcache_flush !== (c == 1)) begin errors++; $display("FAIL both_dcache c=%0d got %b exp %b", c, dcache_flush, c == 1); end
      if (icache_flush !== (c == 2)) begin errors++; $display("FAIL both_icache c=%0d got %b exp %b", c, icache_flush, c == 2); end
      if ({itlb_fence, dtlb_fence} !== {2{c == 3}}) begin errors++; $display("FAIL both_tlb c=%0d got %b exp %b", c, {itlb_fence, dtlb_fence}, {2{c == 3}}); end
      if (fence_done !== (c == 5)) begin errors++; $display("FAIL both_done c=%0d got %b exp %b", c, fence_done, c == 5); end
      if (fence_stall !== (c <= 4)) begin errors++; $display("FAIL both_stall c=%0d got %b exp %b", c, fence_stall, c <= 4); end
      if ({d2_fence_done, d2_itlb_fence} !== {c == 3, 1'b0}) begin errors++; $display("FAIL notrans_both c=%0d got %b exp %b", c, {d2_fence_done, d2_itlb_fence}, {c == 3, 1'b0}); end
      if (c >= 1 && {fence_va, fence_asid, fence_va_valid, fence_asid_valid} !== {32'h1234_5000, 9'd0, 2'b10}) begin
        errors++; $display("FAIL both_latch c=%0d got va=%h asid=%0d v=%b%b exp va=12345000 asid=0 v=10", c, fence_va, fence_asid, fence_va_valid, fence_asid_valid);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 16; c++) begin
      ifence_req = c < 14 && c != 8 && c != 9;
      dflush_done = c == 1 || c == 11; iflush_done = c == 2 || c == 12;
      #1;
      checks += 4;
      if (dcache_flush !== (c == 1 || c == 11)) begin errors++; $display("FAIL b2b_dcache c=%0d got %b exp %b", c, dcache_flush, c == 1 || c == 11); end
      if (icache_flush !== (c == 2 || c == 12)) begin errors++; $display("FAIL b2b_icache c=%0d got %b exp %b", c, icache_flush, c == 2 || c == 12); end
      if (fence_done !== (c == 3 || c == 13)) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, fence_done, c == 3 || c == 13); end
      if (fence_stall !== (c <= 2 || (c >= 10 && c <= 12))) begin
        errors++; $display("FAIL b2b_stall c=%0d got %b exp %b", c, fence_stall, c <= 2 || (c >= 10 && c <= 12));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 21; c++) begin
      ifence_req = c < 19; iflush_done = c == 17;
      #1;
      checks += 5;
      if (dcache_flush !== (c == 1)) begin errors++; $display("FAIL tmo_dcache c=%0d got %b exp %b", c, dcache_flush, c == 1); end
      if (icache_flush !== (c == 17)) begin errors++; $display("FAIL tmo_icache c=%0d got %b exp %b", c, icache_flush, c == 17); end
      if (fence_done !== (c == 18)) begin errors++; $display("FAIL tmo_done c=%0d got %b exp %b", c, fence_done, c == 18); end
      if (fence_stall !== (c <= 17)) begin errors++; $display("FAIL tmo_stall c=%0d got %b exp %b", c, fence_stall, c <= 17); end
      if (fence_timeout !== (c >= 16)) begin errors++; $display("FAIL tmo_flag c=%0d got %b exp %b", c, fence_timeout, c >= 16); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_squash();
    for (int c = 0; c < 3; c++) begin
      ifence_req = 1; squash = 1;
      #1;
      checks += 2;
      if ({dcache_flush, icache_flush, itlb_fence, fence_stall, fence_done} !== 5'd0) begin
        errors++; $display("FAIL squash_idle c=%0d got %b exp 00000", c, {dcache_flush, icache_flush, itlb_fence, fence_stall, fence_done});
      end
      if (fence_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky c=%0d got %b exp 1", c, fence_timeout); end
      tick();
    end
    for (int c = 0; c < 7; c++) begin
      ifence_req = c < 5; squash = c == 2 || c == 3;
      dflush_done = c == 1; iflush_done = c == 3;
      #1;
      checks += 4;
      if (dcache_flush !== (c == 1)) begin errors++; $display("FAIL squash_dcache c=%0d got %b exp %b", c, dcache_flush, c == 1); end
      if (icache_flush !== (c == 2)) begin errors++; $display("FAIL squash_icache c=%0d got %b exp %b", c, icache_flush, c == 2); end
      if (fence_done !== (c == 4)) begin errors++; $display("FAIL squash_done c=%0d got %b exp %b", c, fence_done, c == 4); end
      if (fence_stall !== (c <= 3)) begin errors++; $display("FAIL squash_stall c=%0d got %b exp %b", c, fence_stall, c <= 3); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_tlb();
    sfence_req = 1; rs1_data = 32'hCAFE_0000; rs1_zero = 0; rs2_data = 32'h3; rs2_zero = 0;
    #1;
    checks++;
    if (fence_stall !== 1'b1) begin errors++; $display("FAIL rst_tlb_accept got %b exp 1", fence_stall); end
    tick();
    checks++;
    if ({itlb_fence, dtlb_fence} !== 2'b11) begin errors++; $display("FAIL rst_tlb_issue got %b exp 11", {itlb_fence, dtlb_fence}); end
    tick();
    RST = 1; sfence_req = 0;
    tick();
    RST = 0;
    for (int c = 0; c < 3; c++) begin
      itlb_fence_done = c == 1; dtlb_fence_done = c == 1;
      #1;
      checks += 2;
      if ({icache_flush, dcache_flush, itlb_fence, dtlb_fence, fence_stall, fence_done, fence_timeout} !== 7'd0) begin
        errors++; $display("FAIL rst_tlb_outputs c=%0d got %b exp 0000000", c, {icache_flush, dcache_flush, itlb_fence, dtlb_fence, fence_stall, fence_done, fence_timeout});
      end
      if ({fence_va, fence_asid, fence_va_valid, fence_asid_valid} !== 43'd0) begin
        errors++; $display("FAIL rst_tlb_latch c=%0d got va=%h asid=%h exp 0", c, fence_va, fence_asid);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_ifence();
    test_sfence();
    test_both();
    test_back_to_back();
    test_timeout();
    test_squash();
    test_reset_in_tlb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
